radio_deser: RTL and testbench

RADIO_DESER -- requirements
Module: radio_deser

---
 rtl/radio_deser_pkg.sv | 27 ++
 rtl/radio_deser_if.sv | 27 ++
 rtl/deser_shift.sv | 27 ++
 rtl/radio_deser.sv | 134 +++++++++++++
 tb/tb_radio_deser.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/radio_deser_pkg.sv
// Shared definitions for the radio serial link: word geometry, field layout and lock states.
// Also used by the radio-side serializer, so keep field positions in sync with it.
package radio_deser_pkg;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned FIELD_W   = 2;
    localparam int unsigned ERR_CNT_W = 8;

    // Field LSB positions inside a word
    localparam int unsigned R0_I_LSB = 6;
    localparam int unsigned R0_Q_LSB = 4;
    localparam int unsigned R1_I_LSB = 2;
    localparam int unsigned R1_Q_LSB = 0;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

    function automatic logic [FIELD_W-1:0] get_field(input logic [WORD_W-1:0] w,
                                                     input int unsigned lsb);
        return FIELD_W'(w >> lsb);
    endfunction

endpackage

// File: rtl/radio_deser_if.sv
// Serial input and parallel word/status bus of the radio deserializer.
interface radio_deser_if;
    import radio_deser_pkg::*;

    logic                 data_in;
    logic                 sync_in;
    logic [WORD_W-1:0]    word_out;
    logic [FIELD_W-1:0]   r0_i;
    logic [FIELD_W-1:0]   r0_q;
    logic [FIELD_W-1:0]   r1_i;
    logic [FIELD_W-1:0]   r1_q;
    logic                 word_valid;
    logic                 locked;
    logic                 sync_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output data_in, sync_in,
        input  word_out, r0_i, r0_q, r1_i, r1_q, word_valid, locked, sync_err, err_count
    );

    modport slave (
        input  data_in, sync_in,
        output word_out, r0_i, r0_q, r1_i, r1_q, word_valid, locked, sync_err, err_count
    );

endinterface

// File: rtl/deser_shift.sv
// LSB-first serial-to-parallel shifter with a parallel-load output word register.
module deser_shift
    import radio_deser_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              load,
    output logic [WORD_W-1:0] word
);

    // Holds the previous WORD_W-1 bits; the newest bit lands in the MSB on load
    logic [WORD_W-2:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            word <= '0;
        end else begin
            sr <= {bit_in, sr[WORD_W-2:1]};
            if (load) begin
                word <= {bit_in, sr};
            end
        end
    end

endmodule

// File: rtl/radio_deser.sv
// Radio deserializer: frame lock FSM (hunt/confirm/locked with flywheel) and word emission.
module radio_deser
    import radio_deser_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 2
) (
    input  logic          fast_clk,
    input  logic          rst,
    radio_deser_if.slave  bus
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W = $clog2(UNLOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0]    GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]    MISS_LAST = MISS_W'(UNLOCK_COUNT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(WORD_W - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

    lock_state_e          state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [GOOD_W-1:0]    good_cnt;
    logic [MISS_W-1:0]    miss_cnt;
    logic                 word_valid;
    logic                 locked;
    logic                 sync_err;
    logic [ERR_CNT_W-1:0] err_count;
    logic [WORD_W-1:0]    word_q;

    logic expected_c;
    logic err_c;
    logic load_c;

    // While locked, a framing error is a missing sync on the expected edge or a sync anywhere else
    always_comb begin
        expected_c = (bit_cnt == '0);
        err_c      = (state == ST_LOCKED) && (expected_c ^ bus.sync_in);
        load_c     = (state == ST_LOCKED) && (bit_cnt == BIT_LAST);
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HUNT;
            bit_cnt    <= '0;
            good_cnt   <= '0;
            miss_cnt   <= '0;
            word_valid <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            word_valid <= load_c;
            sync_err   <= err_c;
            bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
            unique case (state)
                ST_HUNT: begin
                    if (bus.sync_in) begin
                        bit_cnt  <= BIT_CNT_W'(1);
                        good_cnt <= GOOD_W'(1);
                        if (LOCK_COUNT <= 1) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (expected_c) begin
                        if (!bus.sync_in) begin
                            state    <= ST_HUNT;
                            good_cnt <= '0;
                        end else if (good_cnt == GOOD_LAST) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                        end
                    end else if (bus.sync_in) begin
                        // Early sync: restart confirmation on the new alignment
                        bit_cnt  <= BIT_CNT_W'(1);
                        good_cnt <= GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: alignment is never moved while locked
                    if (expected_c) begin
                        if (bus.sync_in) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt == MISS_LAST) begin
                            state    <= ST_HUNT;
                            locked   <= 1'b0;
                            miss_cnt <= '0;
                            good_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= ST_HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Saturating framing error counter
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_c && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

    deser_shift u_shift (
        .clk    (fast_clk),
        .rst    (rst),
        .bit_in (bus.data_in),
        .load   (load_c),
        .word   (word_q)
    );

    assign bus.word_out   = word_q;
    assign bus.r0_i       = get_field(word_q, R0_I_LSB);
    assign bus.r0_q       = get_field(word_q, R0_Q_LSB);
    assign bus.r1_i       = get_field(word_q, R1_I_LSB);
    assign bus.r1_q       = get_field(word_q, R1_Q_LSB);
    assign bus.word_valid = word_valid;
    assign bus.locked     = locked;
    assign bus.sync_err   = sync_err;
    assign bus.err_count  = err_count;

endmodule

// File: tb/tb_radio_deser.sv
// Directed bench for radio_deser: lock acquisition, word decode, flywheel, realign, saturation, reset.
module tb_radio_deser;

    logic fast_clk = 1'b0;
    logic rst      = 1'b0;

    radio_deser_if bus ();

    radio_deser #(.LOCK_COUNT(4), .UNLOCK_COUNT(2)) dut (
        .fast_clk (fast_clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 fast_clk = ~fast_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;
    int n_serr = 0;
    int valid_double = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [7:0] w;
        bit         sync;
        int         dvalid;
        logic [7:0] exp_word;
        logic [1:0] r0i, r0q, r1i, r1q;
        bit         exp_locked;
        int         exp_err;
        bit         chk_gap;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one serial bit, advance one edge, then observe outputs
    task automatic send_bit(input logic d, input logic s);
        bus.data_in = d;
        bus.sync_in = s;
        @(posedge fast_clk);
        #1;
        cyc++;
        if (bus.word_valid === 1'b1) begin
            n_valid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            if (prev_valid === 1'b1) valid_double++;
        end
        prev_valid = bus.word_valid;
        if (bus.sync_err === 1'b1) n_serr++;
    endtask

    task automatic send_range(input logic [7:0] w, input bit s0, input int stray,
                              input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_bit(w[i], ((i == 0) && s0) || (i == stray));
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit s0);
        send_range(w, s0, -1, 0, 7);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " word_out"},   32'(bus.word_out),   32'h0);
        chk({tag, " fields"},     32'({bus.r0_i, bus.r0_q, bus.r1_i, bus.r1_q}), 32'h0);
        chk({tag, " word_valid"}, 32'(bus.word_valid), 32'h0);
        chk({tag, " locked"},     32'(bus.locked),     32'h0);
        chk({tag, " sync_err"},   32'(bus.sync_err),   32'h0);
        chk({tag, " err_count"},  32'(bus.err_count),  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_v;
        int base_e;

        tbl[0] = '{8'hB4, 1'b1, 1, 8'hB4, 2'd2, 2'd3, 2'd1, 2'd0, 1'b1, 0, 1'b1};
        tbl[1] = '{8'h5A, 1'b1, 1, 8'h5A, 2'd1, 2'd1, 2'd2, 2'd2, 1'b1, 0, 1'b1};
        tbl[2] = '{8'h3C, 1'b0, 1, 8'h3C, 2'd0, 2'd3, 2'd3, 2'd0, 1'b1, 1, 1'b1};
        tbl[3] = '{8'hC3, 1'b1, 1, 8'hC3, 2'd3, 2'd0, 2'd0, 2'd3, 1'b1, 1, 1'b1};
        tbl[4] = '{8'h11, 1'b0, 1, 8'h11, 2'd0, 2'd1, 2'd0, 2'd1, 1'b1, 2, 1'b1};
        tbl[5] = '{8'h22, 1'b0, 0, 8'h11, 2'd0, 2'd1, 2'd0, 2'd1, 1'b0, 3, 1'b0};
        tbl[6] = '{8'h33, 1'b0, 0, 8'h11, 2'd0, 2'd1, 2'd0, 2'd1, 1'b0, 3, 1'b0};

        bus.data_in = 1'b0;
        bus.sync_in = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk_zero_outputs("reset");
        repeat (2) @(posedge fast_clk);
        #1 rst = 1'b0;

        // Lock acquisition on four 0x00 words
        send_word(8'h00, 1'b1);
        send_word(8'h00, 1'b1);
        send_word(8'h00, 1'b1);
        chk("pre-lock locked", 32'(bus.locked), 32'h0);
        chk("pre-lock valids", 32'(n_valid), 32'h0);
        send_bit(1'b0, 1'b1);
        chk("lock after 4th sync", 32'(bus.locked), 32'h1);
        send_range(8'h00, 1'b0, -1, 1, 7);
        chk("first word valid", 32'(n_valid), 32'h1);
        chk("first word value", 32'(bus.word_out), 32'h0);

        // Locked word table: decode, flywheel, loss of lock
        for (int i = 0; i < 7; i++) begin
            base_v = n_valid;
            send_word(tbl[i].w, tbl[i].sync);
            chk($sformatf("row%0d valids", i), 32'(n_valid - base_v), 32'(tbl[i].dvalid));
            chk($sformatf("row%0d word", i), 32'(bus.word_out), 32'(tbl[i].exp_word));
            chk($sformatf("row%0d r0_i", i), 32'(bus.r0_i), 32'(tbl[i].r0i));
            chk($sformatf("row%0d r0_q", i), 32'(bus.r0_q), 32'(tbl[i].r0q));
            chk($sformatf("row%0d r1_i", i), 32'(bus.r1_i), 32'(tbl[i].r1i));
            chk($sformatf("row%0d r1_q", i), 32'(bus.r1_q), 32'(tbl[i].r1q));
            chk($sformatf("row%0d locked", i), 32'(bus.locked), 32'(tbl[i].exp_locked));
            chk($sformatf("row%0d err_count", i), 32'(bus.err_count), 32'(tbl[i].exp_err));
            chk($sformatf("row%0d sync_err pulses", i), 32'(n_serr), 32'(tbl[i].exp_err));
            if (tbl[i].chk_gap) begin
                chk($sformatf("row%0d valid gap", i), 32'(last_valid_cyc - prev_valid_cyc), 32'd8);
            end
        end

        // Realign in CONFIRM: sync arrives 3 edges early
        base_v = n_valid;
        send_word(8'h12, 1'b1);
        send_range(8'h34, 1'b1, -1, 0, 4);
        send_word(8'h56, 1'b1);
        chk("realign locked", 32'(bus.locked), 32'h0);
        send_word(8'h78, 1'b1);
        send_word(8'h9A, 1'b1);
        chk("realign pre-lock locked", 32'(bus.locked), 32'h0);
        chk("realign pre-lock valids", 32'(n_valid - base_v), 32'h0);
        send_word(8'hA5, 1'b1);
        chk("realign locked after", 32'(bus.locked), 32'h1);
        chk("realign valids", 32'(n_valid - base_v), 32'h1);
        chk("realign word", 32'(bus.word_out), 32'hA5);
        chk("realign err_count", 32'(bus.err_count), 32'd3);

        // Stray syncs at bit 4 drive the error counter into saturation
        base_v = n_valid;
        base_e = n_serr;
        for (int i = 0; i < 251; i++) send_range(8'h69, 1'b1, 4, 0, 7);
        chk("stray err_count 254", 32'(bus.err_count), 32'd254);
        send_range(8'h69, 1'b1, 4, 0, 7);
        chk("stray err_count 255", 32'(bus.err_count), 32'd255);
        for (int i = 0; i < 48; i++) send_range(8'h69, 1'b1, 4, 0, 7);
        chk("stray err_count sat", 32'(bus.err_count), 32'd255);
        chk("stray locked", 32'(bus.locked), 32'h1);
        chk("stray valids", 32'(n_valid - base_v), 32'd300);
        chk("stray sync_err pulses", 32'(n_serr - base_e), 32'd300);
        chk("stray word", 32'(bus.word_out), 32'h69);

        // Asynchronous reset during bit 5 of a word
        send_range(8'hFF, 1'b1, -1, 0, 4);
        bus.data_in = 1'b1;
        bus.sync_in = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk_zero_outputs("midword reset");
        base_v = n_valid;
        for (int i = 5; i < 8; i++) send_bit(1'b1, 1'b0);
        rst = 1'b0;
        chk("midword reset valids", 32'(n_valid - base_v), 32'h0);
        send_word(8'h01, 1'b1);
        send_word(8'h02, 1'b1);
        send_word(8'h03, 1'b1);
        chk("relock pre locked", 32'(bus.locked), 32'h0);
        chk("relock pre valids", 32'(n_valid - base_v), 32'h0);
        send_word(8'h77, 1'b1);
        chk("relock locked", 32'(bus.locked), 32'h1);
        chk("relock valids", 32'(n_valid - base_v), 32'h1);
        chk("relock word", 32'(bus.word_out), 32'h77);
        chk("relock err_count", 32'(bus.err_count), 32'h0);

        chk("word_valid one-cycle", 32'(valid_double), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
